image_frame_buffer: RTL and testbench

Parametrised double-buffered (ping-pong) frame store that replaces the fixed 2500-entry, 8-bit image array currently fed to the pipeline. A producer streams pixels in through a valid/ready handshake while the pipeline reads the previous complete frame through a 1-cycle-latency random-access port. Generalised in pixel width, frame geometry and channel count; frame hand-over between producer and pipeline is explicit.

---
 rtl/image_frame_buffer_if.sv | 46 ++++
 rtl/image_frame_buffer.sv | 90 +++++++++
 tb/tb_image_frame_buffer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/image_frame_buffer_if.sv
// image_frame_buffer_if: producer/consumer bus for the ping-pong frame store.
// Ports: in_valid/in_ready/in_data pixel stream; frame_avail, rd_en/rd_addr,
// rd_data/rd_valid/rd_err read port; rd_release frame hand-back;
// frames_done counter; checksum when FRAME_BUF_CHECKSUM_EN is defined.
// The slave modport is the buffer; the master modport is the producer/consumer.
interface image_frame_buffer_if #(
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 1,
    parameter int IMG_W    = 50,
    parameter int IMG_H    = 50
);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int DW     = PIX_W * CHANNELS;

    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              frame_avail;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              rd_release;
    logic [15:0]       frames_done;
`ifdef FRAME_BUF_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    modport slave (
        input  in_valid, in_data, rd_en, rd_addr, rd_release,
        output in_ready, frame_avail, rd_data, rd_valid, rd_err, frames_done
`ifdef FRAME_BUF_CHECKSUM_EN
        , output checksum
`endif
    );

    modport master (
        output in_valid, in_data, rd_en, rd_addr, rd_release,
        input  in_ready, frame_avail, rd_data, rd_valid, rd_err, frames_done
`ifdef FRAME_BUF_CHECKSUM_EN
        , input checksum
`endif
    );
endinterface

// File: rtl/image_frame_buffer.sv
// image_frame_buffer: double-buffered (ping-pong) frame store.
// Ports: clk, rst (synchronous, active high), bus (image_frame_buffer_if.slave).
// A producer fills bank wr_sel through a valid/ready stream while the consumer
// reads the last complete frame in bank rd_sel with 1-cycle latency, then hands
// it back with rd_release. Optional macro FRAME_BUF_CHECKSUM_EN adds a 32-bit
// per-frame sum of all channel samples on bus.checksum.
module image_frame_buffer #(
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 1,
    parameter int IMG_W    = 50,
    parameter int IMG_H    = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    image_frame_buffer_if.slave   bus
);
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int DW     = PIX_W * CHANNELS;
    // One extra bit so the range check also works when NPIX is a power of two.
    localparam logic [ADDR_W:0]   LIM  = (ADDR_W+1)'(NPIX);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    logic [DW-1:0]     mem [2][NPIX];
    logic [ADDR_W-1:0] wr_cnt;
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        full;
    logic              wr_go;
    logic              wr_last;
    logic              rel_go;
    logic              rd_ok;

    assign bus.in_ready    = !full[wr_sel];
    assign bus.frame_avail = full[rd_sel];
    assign wr_go   = bus.in_valid && !full[wr_sel];
    assign wr_last = wr_go && wr_cnt == LAST;
    assign rel_go  = bus.rd_release && full[rd_sel];
    assign rd_ok   = bus.rd_en && full[rd_sel] && {1'b0, bus.rd_addr} < LIM;

    always_ff @(posedge clk)
        if (wr_go) mem[wr_sel][wr_cnt] <= bus.in_data;

    // Completion and release always target different banks (one is filling,
    // the other is full), so the set and clear masks never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt          <= '0;
            wr_sel          <= 1'b0;
            rd_sel          <= 1'b0;
            full            <= 2'b00;
            bus.frames_done <= '0;
            bus.rd_data     <= '0;
            bus.rd_valid    <= 1'b0;
            bus.rd_err      <= 1'b0;
        end else begin
            if (wr_go) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
            if (wr_last) wr_sel <= !wr_sel;
            if (wr_last) bus.frames_done <= bus.frames_done + 16'd1;
            if (rel_go) rd_sel <= !rd_sel;
            full <= (full | (wr_last ? 2'b01 << wr_sel : 2'b00))
                  & ~(rel_go ? 2'b01 << rd_sel : 2'b00);
            bus.rd_data  <= rd_ok ? mem[rd_sel][bus.rd_addr] : '0;
            bus.rd_valid <= rd_ok;
            bus.rd_err   <= bus.rd_en && !rd_ok;
        end
    end

`ifdef FRAME_BUF_CHECKSUM_EN
    logic [31:0] samp_sum;
    logic [31:0] acc_sum;

    always_comb begin
        samp_sum = '0;
        for (int c = 0; c < CHANNELS; c++)
            samp_sum = samp_sum + 32'(bus.in_data[c*PIX_W +: PIX_W]);
    end

    // Clearing on the last pixel is the same as clearing at the next frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sum      <= '0;
            bus.checksum <= '0;
        end else if (wr_go) begin
            acc_sum <= wr_last ? '0 : acc_sum + samp_sum;
            if (wr_last) bus.checksum <= acc_sum + samp_sum;
        end
    end
`endif
endmodule

// File: tb/tb_image_frame_buffer.sv
// tb_image_frame_buffer: directed self-checking bench for image_frame_buffer.
module tb_image_frame_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = !clk;

    image_frame_buffer_if bus ();
    image_frame_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        en;
        logic [11:0] addr;
        logic        valid;
        logic        err;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] base, input int n, input bit rel_last);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            bus.in_valid   = 1'b1;
            bus.in_data    = 8'(i) + base;
            bus.rd_release = rel_last && i == n - 1;
            while (!bus.in_ready && w < 100) begin
                tick();
                w++;
            end
            if (w == 100) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: pixel %0d never accepted, required in_ready=1", i);
            end
            tick();
        end
        bus.in_valid   = 1'b0;
        bus.rd_release = 1'b0;
    endtask

    task automatic read(input logic [11:0] addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 12'd300,  1'b1, 1'b0, 8'h2C};
        vecs[1] = '{1'b1, 12'd0,    1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 12'd2499, 1'b1, 1'b0, 8'hC3};
        vecs[3] = '{1'b1, 12'd2500, 1'b0, 1'b1, 8'h00};
        vecs[4] = '{1'b1, 12'd1023, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{1'b1, 12'd4095, 1'b0, 1'b1, 8'h00};
        vecs[6] = '{1'b0, 12'd300,  1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 12'd256,  1'b1, 1'b0, 8'h00};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", 32'(bus.in_ready), 1);
        chk("reset_frame_avail", 32'(bus.frame_avail), 0);
        chk("reset_rd_valid", 32'(bus.rd_valid), 0);
        chk("reset_rd_err", 32'(bus.rd_err), 0);
        chk("reset_rd_data", 32'(bus.rd_data), 0);
        chk("reset_frames_done", 32'(bus.frames_done), 0);
`ifdef FRAME_BUF_CHECKSUM_EN
        chk("reset_checksum", bus.checksum, 0);
`endif

        read(12'd5);
        chk("early_read_err", 32'(bus.rd_err), 1);
        chk("early_read_valid", 32'(bus.rd_valid), 0);
        chk("early_read_data", 32'(bus.rd_data), 0);
        tick();
        chk("err_is_pulse", 32'(bus.rd_err), 0);

        push_frame(8'h00, 1000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midframe_rst_avail", 32'(bus.frame_avail), 0);
        chk("midframe_rst_in_ready", 32'(bus.in_ready), 1);
        chk("midframe_rst_frames_done", 32'(bus.frames_done), 0);

        push_frame(8'h00, 2500, 1'b0);
        chk("frame1_avail", 32'(bus.frame_avail), 1);
        chk("frame1_frames_done", 32'(bus.frames_done), 1);
        chk("frame1_in_ready", 32'(bus.in_ready), 1);
`ifdef FRAME_BUF_CHECKSUM_EN
        begin
            logic [31:0] sum;
            sum = 0;
            for (int i = 0; i < 2500; i++) sum += 32'(i % 256);
            chk("frame1_checksum", bus.checksum, sum);
        end
`endif

        foreach (vecs[k]) begin
            bus.rd_en   = vecs[k].en;
            bus.rd_addr = vecs[k].addr;
            tick();
            chk($sformatf("vec%0d_valid", k), 32'(bus.rd_valid), 32'(vecs[k].valid));
            chk($sformatf("vec%0d_err", k), 32'(bus.rd_err), 32'(vecs[k].err));
            chk($sformatf("vec%0d_data", k), 32'(bus.rd_data), 32'(vecs[k].data));
        end
        bus.rd_en = 1'b0;

        push_frame(8'h40, 2500, 1'b0);
        chk("both_full_in_ready", 32'(bus.in_ready), 0);
        chk("both_full_frames_done", 32'(bus.frames_done), 2);
        chk("both_full_avail", 32'(bus.frame_avail), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h80;
        repeat (3) tick();
        chk("held_in_ready", 32'(bus.in_ready), 0);
        bus.rd_en      = 1'b1;
        bus.rd_addr    = 12'd300;
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        chk("release_read_pre_bank", 32'(bus.rd_data), 32'h2C);
        chk("release_in_ready", 32'(bus.in_ready), 1);
        chk("release_avail", 32'(bus.frame_avail), 1);
        bus.in_valid = 1'b0;
        read(12'd300);
        chk("frame2_read", 32'(bus.rd_data), 32'h6C);
        chk("frame2_read_valid", 32'(bus.rd_valid), 1);

        push_frame(8'h80, 2500, 1'b1);
        chk("coincide_avail", 32'(bus.frame_avail), 1);
        chk("coincide_in_ready", 32'(bus.in_ready), 1);
        chk("coincide_frames_done", 32'(bus.frames_done), 3);
        read(12'd300);
        chk("frame3_read_300", 32'(bus.rd_data), 32'hAC);
        read(12'd2499);
        chk("frame3_read_2499", 32'(bus.rd_data), 32'h43);

        bus.rd_en   = 1'b1;
        bus.rd_addr = 12'd300;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rd_en = 1'b0;
        chk("rst_read_valid", 32'(bus.rd_valid), 0);
        chk("rst_read_data", 32'(bus.rd_data), 0);
        chk("rst_avail", 32'(bus.frame_avail), 0);
        chk("rst_frames_done", 32'(bus.frames_done), 0);
`ifdef FRAME_BUF_CHECKSUM_EN
        chk("rst_checksum", bus.checksum, 0);
`endif
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        chk("idle_release_avail", 32'(bus.frame_avail), 0);
        chk("idle_release_in_ready", 32'(bus.in_ready), 1);
        read(12'd10);
        chk("idle_read_err", 32'(bus.rd_err), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
